serial_sum_recover: RTL and testbench

- Bit-serial subtractor. It takes a 7-bit Sum and the 5-bit operand A that produced it, and recovers the 6-bit operand B = Sum - A.
- It is the inverse of the 5-bit + 6-bit ripple adder in the ALU datapath.
- It uses one full-subtractor cell, processing one bit per clock, LSB first.
- It has a start/busy/done handshake and is used by the ALU checker and the undo path.

---
 rtl/serial_sum_recover_pkg.sv | 14 +
 rtl/serial_sum_recover_if.sv | 28 ++
 rtl/serial_sum_recover_fs_cell.sv | 11 +
 rtl/serial_sum_recover.sv | 124 ++++++++++++
 tb/tb_serial_sum_recover.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/serial_sum_recover_pkg.sv
// Shared types and default sizes for the bit-serial Sum - A recovery unit.
package serial_sum_recover_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int A_W_DEF   = 5;
    localparam int S_W_DEF   = 7;
    localparam int CNT_W_DEF = $clog2(S_W_DEF);

endpackage

// File: rtl/serial_sum_recover_if.sv
// Request/result bundle between a client and the serial subtractor.
interface serial_sum_recover_if
    import serial_sum_recover_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int S_W = S_W_DEF
);
    localparam int B_W = S_W - 1;

    logic           start;
    logic [S_W-1:0] Sum;
    logic [A_W-1:0] A;
    logic [B_W-1:0] B;
    logic           underflow;
    logic           range_err;
    logic           busy;
    logic           done;

    modport master (
        output start, Sum, A,
        input  B, underflow, range_err, busy, done
    );

    modport slave (
        input  start, Sum, A,
        output B, underflow, range_err, busy, done
    );
endinterface

// File: rtl/serial_sum_recover_fs_cell.sv
// One-bit full subtractor: D = A - B - BI, BO is the borrow out.
module fs_cell (
    input  logic A,
    input  logic B,
    input  logic BI,
    output logic D,
    output logic BO
);
    assign D  = A ^ B ^ BI;
    assign BO = (~A & B) | (~A & BI) | (B & BI);
endmodule

// File: rtl/serial_sum_recover.sv
// Recovers B = Sum - A one bit per clock, LSB first, using a single fs_cell.
module serial_sum_recover
    import serial_sum_recover_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int S_W = S_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_sum_recover_if.slave  bus
);
    localparam int B_W   = S_W - 1;
    localparam int CNT_W = $clog2(S_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(S_W - 1);

    state_t           state_q, state_d;
    logic [S_W-1:0]   m_q, m_d;
    logic [S_W-1:0]   s_q, s_d;
    logic [S_W-1:0]   diff_q, diff_d;
    logic             bw_q, bw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [B_W-1:0]   b_q, b_d;
    logic             underflow_q, underflow_d;
    logic             range_err_q, range_err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic cell_d;
    logic cell_bo;

    fs_cell u_cell (
        .A  (m_q[0]),
        .B  (s_q[0]),
        .BI (bw_q),
        .D  (cell_d),
        .BO (cell_bo)
    );

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        s_d         = s_q;
        diff_d      = diff_q;
        bw_d        = bw_q;
        cnt_d       = cnt_q;
        b_d         = b_q;
        underflow_d = underflow_q;
        range_err_d = range_err_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = bus.Sum;
                    s_d     = {{(S_W-A_W){1'b0}}, bus.A};
                    diff_d  = '0;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                diff_d = {cell_d, diff_q[S_W-1:1]};
                m_d    = {1'b0, m_q[S_W-1:1]};
                s_d    = {1'b0, s_q[S_W-1:1]};
                bw_d   = cell_bo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // The final difference bit is still in flight, so the low B_W
                    // bits of the finished result are diff_q's upper bits.
                    b_d         = diff_q[S_W-1:1];
                    underflow_d = cell_bo;
                    range_err_d = cell_d & ~cell_bo;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m_q         <= '0;
            s_q         <= '0;
            diff_q      <= '0;
            bw_q        <= 1'b0;
            cnt_q       <= '0;
            b_q         <= '0;
            underflow_q <= 1'b0;
            range_err_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            diff_q      <= diff_d;
            bw_q        <= bw_d;
            cnt_q       <= cnt_d;
            b_q         <= b_d;
            underflow_q <= underflow_d;
            range_err_q <= range_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.B         = b_q;
    assign bus.underflow = underflow_q;
    assign bus.range_err = range_err_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_sum_recover.sv
// Directed bench for serial_sum_recover: latency, arithmetic corners, start filtering, abort.
module tb_serial_sum_recover;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_sum_recover_if #(.A_W(5), .S_W(7)) bus ();

    serial_sum_recover #(.A_W(5), .S_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.Sum   = 7'd40;
        bus.A     = 5'd9;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b0;
        checks += 5;
        if (bus.B !== 6'd0)        begin errors++; $display("FAIL reset_B: got %0d want 0", bus.B); end
        if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", bus.underflow); end
        if (bus.range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err: got %b want 0", bus.range_err); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy (rst beats start): got %b want 0", bus.busy); end
        if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset_busy: got %b want 0", bus.busy); end
    endtask

    // Issues one operation from IDLE and checks latency, busy length, results and done width.
    task automatic run_op(input string name, input logic [6:0] sum, input logic [4:0] a,
                          input logic [5:0] exp_b, input logic exp_uf, input logic exp_re);
        int n;
        int bc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Sum   = sum;
        bus.A     = a;
        @(negedge clk);
        bus.start = 1'b0;
        n  = 1;
        bc = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            if (bus.busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        $display("op %s: Sum=%0d A=%0d -> B=%0d underflow=%b range_err=%b edges=%0d busy_cycles=%0d",
                 name, sum, a, bus.B, bus.underflow, bus.range_err, n, bc);
        checks += 5;
        if (n != 8)                   begin errors++; $display("FAIL %s_latency: got %0d edges want 8", name, n); end
        if (bc != 7)                  begin errors++; $display("FAIL %s_busy_len: got %0d want 7", name, bc); end
        if (bus.B !== exp_b)          begin errors++; $display("FAIL %s_B: got %0d want %0d", name, bus.B, exp_b); end
        if (bus.underflow !== exp_uf) begin errors++; $display("FAIL %s_underflow: got %b want %b", name, bus.underflow, exp_uf); end
        if (bus.range_err !== exp_re) begin errors++; $display("FAIL %s_range_err: got %b want %b", name, bus.range_err, exp_re); end
        @(negedge clk);
        checks += 2;
        if (bus.done !== 1'b0)  begin errors++; $display("FAIL %s_done_pulse: got %b want 0", name, bus.done); end
        if (bus.B !== exp_b)    begin errors++; $display("FAIL %s_B_hold: got %0d want %0d", name, bus.B, exp_b); end
    endtask

    task automatic test_legal();
        run_op("legal", 7'd40, 5'd9, 6'd31, 1'b0, 1'b0);
        run_op("max_legal", 7'd94, 5'd31, 6'd63, 1'b0, 1'b0);
    endtask

    task automatic test_underflow();
        run_op("underflow", 7'd3, 5'd5, 6'h3E, 1'b1, 1'b0);
    endtask

    task automatic test_range();
        run_op("range", 7'd127, 5'd0, 6'd63, 1'b0, 1'b1);
    endtask

    task automatic test_ignored_start();
        int n;
        int dc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Sum   = 7'd50;
        bus.A     = 5'd20;
        @(negedge clk);
        n  = 1;
        dc = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            bus.Sum = 7'($urandom);
            bus.A   = 5'($urandom);
            @(negedge clk);
            n++;
        end
        if (bus.done === 1'b1) dc++;
        // start is still high on this DONE cycle and must be dropped, not queued.
        bus.start = 1'b0;
        $display("op ignored_start: Sum=50 A=20 -> B=%0d edges=%0d", bus.B, n);
        checks += 2;
        if (n != 8)           begin errors++; $display("FAIL ignored_latency: got %0d edges want 8", n); end
        if (bus.B !== 6'd30)  begin errors++; $display("FAIL ignored_B: got %0d want 30", bus.B); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dc++;
        end
        checks += 3;
        if (dc != 1)           begin errors++; $display("FAIL ignored_done_count: got %0d want 1", dc); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_requeue_busy: got %b want 0", bus.busy); end
        if (bus.B !== 6'd30)   begin errors++; $display("FAIL ignored_B_hold: got %0d want 30", bus.B); end
        run_op("after_ignored", 7'd60, 5'd17, 6'd43, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int dc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Sum   = 7'd100;
        bus.A     = 5'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("op reset_mid: Sum=100 A=1 aborted, B=%0d busy=%b done=%b", bus.B, bus.busy, bus.done);
        checks += 5;
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0)      begin errors++; $display("FAIL abort_done: got %b want 0", bus.done); end
        if (bus.B !== 6'd0)         begin errors++; $display("FAIL abort_B: got %0d want 0", bus.B); end
        if (bus.underflow !== 1'b0) begin errors++; $display("FAIL abort_underflow: got %b want 0", bus.underflow); end
        if (bus.range_err !== 1'b0) begin errors++; $display("FAIL abort_range_err: got %b want 0", bus.range_err); end
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dc++;
        end
        checks++;
        if (dc != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", dc); end
        run_op("after_abort", 7'd10, 5'd4, 6'd6, 1'b0, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.Sum   = '0;
        bus.A     = '0;
        test_reset();
        test_legal();
        test_underflow();
        test_range();
        test_ignored_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
